// File: rtl/wr_rptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : wr_rptr_sync
// Brief    : Write-domain read-pointer synchroniser with fill level, almost-full
//            and sticky Gray-error / overflow flags for the dcfifo.
// Revision : 1.0 - initial release
// ============================================================================
module wr_rptr_sync #(
    parameter int PTR_WITH     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 12
) (
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic [PTR_WITH:0]   rd_gray,
    input  logic [PTR_WITH:0]   wr_gray,
    input  logic                wr_en,
    input  logic                wr_full,
    input  logic                err_clr,
    output logic [PTR_WITH:0]   rd_gray_sync_wr,
    output logic [PTR_WITH:0]   wr_level,
    output logic                wr_almost_full,
    output logic                gray_err,
    output logic                wr_ovf
);

    localparam int                c_W     = PTR_WITH + 1;
    localparam logic [PTR_WITH:0] c_DEPTH = c_W'(2 ** PTR_WITH);
    localparam logic [PTR_WITH:0] c_AFULL = c_W'(AFULL_THRESH);
    localparam logic [PTR_WITH:0] c_ONE   = c_W'(1);

    function automatic logic [PTR_WITH:0] gray2bin(input logic [PTR_WITH:0] g);
        logic [PTR_WITH:0] b;
        b[PTR_WITH] = g[PTR_WITH];
        for (int i = PTR_WITH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WITH:0] sync_q [SYNC_STAGES];
    logic [PTR_WITH:0] sync_d [SYNC_STAGES];
    logic [PTR_WITH:0] prev_q, prev_d;
    logic [PTR_WITH:0] wr_level_q, wr_level_d;
    logic              wr_almost_full_q, wr_almost_full_d;
    logic              gray_err_q, gray_err_d;
    logic              wr_ovf_q, wr_ovf_d;

    logic [PTR_WITH:0] rd_bin;
    logic [PTR_WITH:0] wr_bin;
    logic [PTR_WITH:0] lvl;
    logic [PTR_WITH:0] gray_delta;
    logic              multi_bit_step;

    // Plain shift chain: each stage is a straight copy, no combining between stages.
    always_comb begin
        sync_d[0] = rd_gray;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k - 1];
        end
    end

    assign rd_gray_sync_wr = sync_q[SYNC_STAGES - 1];

    assign rd_bin = gray2bin(rd_gray_sync_wr);
    assign wr_bin = gray2bin(wr_gray);
    // Modulo subtraction; the extra pointer bit resolves wrap-around.
    assign lvl    = wr_bin - rd_bin;

    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    assign gray_delta     = rd_gray_sync_wr ^ prev_q;
    assign multi_bit_step = |(gray_delta & (gray_delta - c_ONE));

    always_comb begin
        prev_d           = rd_gray_sync_wr;
        wr_level_d       = lvl;
        wr_almost_full_d = (lvl >= c_AFULL);
        gray_err_d       = (lvl > c_DEPTH) | multi_bit_step | (gray_err_q & ~err_clr);
        wr_ovf_d         = (wr_en & wr_full) | (wr_ovf_q & ~err_clr);
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q           <= '0;
            wr_level_q       <= '0;
            wr_almost_full_q <= 1'b0;
            gray_err_q       <= 1'b0;
            wr_ovf_q         <= 1'b0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q           <= prev_d;
            wr_level_q       <= wr_level_d;
            wr_almost_full_q <= wr_almost_full_d;
            gray_err_q       <= gray_err_d;
            wr_ovf_q         <= wr_ovf_d;
        end
    end

    assign wr_level       = wr_level_q;
    assign wr_almost_full = wr_almost_full_q;
    assign gray_err       = gray_err_q;
    assign wr_ovf         = wr_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_rptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_rptr_sync
// Brief    : Scoreboard bench for wr_rptr_sync: directed cases then random pointers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_rptr_sync;

    localparam int PW    = 4;
    localparam int S     = 2;
    localparam int TH    = 12;
    localparam int W     = PW + 1;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    logic         clk_wr  = 1'b0;
    logic         rst_wr  = 1'b1;
    logic [W-1:0] rd_gray = '0;
    logic [W-1:0] wr_gray = '0;
    logic         wr_en   = 1'b0;
    logic         wr_full = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] rd_gray_sync_wr;
    logic [W-1:0] wr_level;
    logic         wr_almost_full;
    logic         gray_err;
    logic         wr_ovf;

    wr_rptr_sync #(
        .PTR_WITH     (PW),
        .SYNC_STAGES  (S),
        .AFULL_THRESH (TH)
    ) dut (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .rd_gray         (rd_gray),
        .wr_gray         (wr_gray),
        .wr_en           (wr_en),
        .wr_full         (wr_full),
        .err_clr         (err_clr),
        .rd_gray_sync_wr (rd_gray_sync_wr),
        .wr_level        (wr_level),
        .wr_almost_full  (wr_almost_full),
        .gray_err        (gray_err),
        .wr_ovf          (wr_ovf)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic [W-1:0] sync;
        logic [W-1:0] level;
        logic         af;
        logic         gerr;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] hist[$];
    logic [W-1:0] m_prev;
    logic         m_gerr;
    logic         m_ovf;
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Inverse by search over all codes rather than by bit recurrence.
    function automatic int to_bin(input logic [W-1:0] g);
        for (int b = 0; b < MOD; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back('0);
        m_prev = '0;
        m_gerr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge rst_wr) reset_model();

    // Reference: the synchronised pointer is simply the rd_gray seen S edges ago.
    always @(posedge clk_wr) begin : p_model
        exp_t         e;
        logic [W-1:0] old_sync;
        int           lvl;
        if (rst_wr) begin
            reset_model();
            e = '{sync: '0, level: '0, af: 1'b0, gerr: 1'b0, ovf: 1'b0};
        end else begin
            old_sync = hist[S-1];
            lvl      = (to_bin(wr_gray) - to_bin(old_sync) + MOD) % MOD;
            m_gerr   = (lvl > DEPTH) || ($countones(old_sync ^ m_prev) > 1) || (m_gerr && !err_clr);
            m_ovf    = (wr_en && wr_full) || (m_ovf && !err_clr);
            m_prev   = old_sync;
            hist.push_front(rd_gray);
            void'(hist.pop_back());
            e.sync  = hist[S-1];
            e.level = W'(lvl);
            e.af    = (lvl >= TH);
            e.gerr  = m_gerr;
            e.ovf   = m_ovf;
        end
        exp_q.push_back(e);
    end

    always @(posedge clk_wr) begin : p_monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1 (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            chk("sb_sync",  rd_gray_sync_wr, e.sync);
            chk("sb_level", wr_level,        e.level);
            chk("sb_afull", wr_almost_full,  e.af);
            chk("sb_gerr",  gray_err,        e.gerr);
            chk("sb_ovf",   wr_ovf,          e.ovf);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_wr);
    endtask

    task automatic do_reset();
        @(negedge clk_wr);
        rst_wr  = 1'b1;
        rd_gray = '0;
        wr_gray = '0;
        wr_en   = 1'b0;
        wr_full = 1'b0;
        err_clr = 1'b0;
        cyc(2);
        rst_wr  = 1'b0;
    endtask

    task automatic walk_rd(input int from, input int to);
        for (int b = from + 1; b <= to; b++) begin
            rd_gray = to_gray(b);
            cyc(1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sync"},  rd_gray_sync_wr, 0);
        chk({tag, "_level"}, wr_level,        0);
        chk({tag, "_afull"}, wr_almost_full,  0);
        chk({tag, "_gerr"},  gray_err,        0);
        chk({tag, "_ovf"},   wr_ovf,          0);
    endtask

    initial begin : p_stim
        int rb;
        int wb;
        cyc(2);
        chk_all_zero("reset");
        rst_wr = 1'b0;

        // Case 1: basic latency and level
        rd_gray = 5'b00010;
        wr_gray = 5'b01111;
        cyc(2);
        chk("c1_sync", rd_gray_sync_wr, 5'b00010);
        cyc(1);
        chk("c1_level", wr_level, 7);
        chk("c1_afull", wr_almost_full, 0);

        // Case 2: wrap-around through the pointer MSB
        do_reset();
        wr_gray = to_gray(14);
        walk_rd(0, 14);
        cyc(3);
        wr_gray = 5'b11011;
        cyc(3);
        chk("c2_level", wr_level, 4);
        chk("c2_afull", wr_almost_full, 0);
        chk("c2_gerr",  gray_err, 0);

        // Case 3: completely full
        do_reset();
        wr_gray = 5'b11000;
        cyc(2);
        chk("c3_level", wr_level, 16);
        chk("c3_afull", wr_almost_full, 1);
        chk("c3_gerr",  gray_err, 0);

        // Case 4: illegal two-bit Gray step, sticky until cleared
        do_reset();
        wr_gray = to_gray(4);
        rd_gray = 5'b00011;
        cyc(2);
        chk("c4_gerr_early", gray_err, 0);
        cyc(1);
        chk("c4_gerr_set", gray_err, 1);
        cyc(4);
        chk("c4_gerr_hold", gray_err, 1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("c4_gerr_clr", gray_err, 0);

        // Case 5: overflow, and set beating clear in the same cycle
        do_reset();
        wr_en   = 1'b1;
        wr_full = 1'b1;
        cyc(1);
        wr_en   = 1'b0;
        wr_full = 1'b0;
        chk("c5_ovf_set", wr_ovf, 1);
        cyc(2);
        chk("c5_ovf_hold", wr_ovf, 1);
        err_clr = 1'b1;
        wr_en   = 1'b1;
        wr_full = 1'b1;
        cyc(1);
        chk("c5_ovf_set_wins", wr_ovf, 1);
        wr_en   = 1'b0;
        wr_full = 1'b0;
        cyc(1);
        err_clr = 1'b0;
        chk("c5_ovf_clr", wr_ovf, 0);

        // Case 6: asynchronous reset in the middle of case 1
        do_reset();
        rd_gray = 5'b00010;
        wr_gray = 5'b01111;
        cyc(4);
        chk("c6_level_pre", wr_level, 7);
        rst_wr = 1'b1;
        #1;
        chk_all_zero("c6_async");
        cyc(2);
        rst_wr = 1'b0;
        chk("c6_level_post", wr_level, 0);

        // Random pointer traffic with occasional corrupted read pointers
        do_reset();
        rb = 0;
        wb = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0 && (wb - rb) < DEPTH) wb++;
            if ($urandom_range(0, 2) == 0 && rb < wb) rb++;
            wr_gray = to_gray(wb);
            if ($urandom_range(0, 99) == 0) rd_gray = W'($urandom);
            else                            rd_gray = to_gray(rb);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_full = ((wb - rb) >= DEPTH) || ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            cyc(1);
        end
        wr_en   = 1'b0;
        err_clr = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
